// File: rtl/system_bd_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : system_bd_pio_pkg
//  Description : Shared constants for the system_bd PIO blocks: the register
//                word map, edge-type encodings and the Avalon data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package system_bd_pio_pkg;

  localparam int DATA_W = 32;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;

  // Edge selection applied to the synchronized inputs
  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage
`default_nettype wire

// File: rtl/system_bd_sys_gpio_in_if.sv
`default_nettype none
// ============================================================================
//  Module      : system_bd_sys_gpio_in_if
//  Description : Avalon-MM slave bus for the input PIO (zero read latency,
//                no wait states).
//  Signals     : address[1:0], chipselect, write_n, writedata[31:0]
//                (master -> slave); readdata[31:0] (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface system_bd_sys_gpio_in_if;
  import system_bd_pio_pkg::*;

  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/system_bd_sys_gpio_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_sync
//  Description : WIDTH-bit, STAGES-deep flop synchronizer with asynchronous
//                active-low reset. Reusable by any input PIO.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_d[WIDTH-1:0]  - asynchronous inputs
//                o_q[WIDTH-1:0]  - inputs synchronized into clk
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_d,
  output      logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/system_bd_sys_gpio_in.sv
`default_nettype none
// ============================================================================
//  Module      : system_bd_sys_gpio_in
//  Description : Avalon-MM input PIO. Synchronizes external inputs, latches
//                per-bit edges in a write-1-to-clear register and raises a
//                level interrupt for unmasked captured edges.
//  Ports       : clk, reset_n         - clock, async active-low reset
//                bus (slave)          - Avalon-MM register access
//                in_port[WIDTH-1:0]   - asynchronous external inputs
//                irq                  - registered level interrupt
//  Registers   : 0 DATA (RO), 1 IRQ_MASK (RW), 2 EDGE_CAPTURE (W1C),
//                3 reserved (reads 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module system_bd_sys_gpio_in
  import system_bd_pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  system_bd_sys_gpio_in_if.slave       bus,
  input  wire logic [WIDTH-1:0]        in_port,
  output      logic                    irq
);

  // Counter saturates here; edges are ignored until then so that the
  // synchronizer filling with a level held across reset looks like no edge.
  localparam logic [2:0] c_WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  w_data_in;
  logic [WIDTH-1:0]  w_edge;
  logic [WIDTH-1:0]  w_clr;
  logic [DATA_W-1:0] w_readdata;
  logic              w_wr;
  logic              w_warm_done;

  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_irq_mask;
  logic [WIDTH-1:0]  r_edge_capture;
  logic [2:0]        r_warm;
  logic              r_irq;

  gpio_in_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (in_port),
    .o_q   (w_data_in)
  );

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_warm_done = (r_warm == c_WARM_MAX);
  assign w_clr       = (w_wr && bus.address == ADDR_EDGE_CAPTURE)
                       ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    case (EDGE_TYPE)
      int'(EDGE_FALLING): w_edge = ~w_data_in & r_prev;
      int'(EDGE_ANY):     w_edge = w_data_in ^ r_prev;
      default:            w_edge = w_data_in & ~r_prev;
    endcase
    if (!w_warm_done) w_edge = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev         <= '0;
      r_irq_mask     <= RESET_VALUE[WIDTH-1:0];
      r_edge_capture <= '0;
      r_warm         <= '0;
      r_irq          <= 1'b0;
    end else begin
      r_prev <= w_data_in;
      if (!w_warm_done) r_warm <= r_warm + 3'd1;
      if (w_wr && bus.address == ADDR_IRQ_MASK)
        r_irq_mask <= bus.writedata[WIDTH-1:0];
      // OR-ing the new edges after the clear makes a same-cycle set win.
      r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
      r_irq          <= |(r_edge_capture & r_irq_mask);
    end
  end

  always_comb begin
    w_readdata = '0;
    case (bus.address)
      ADDR_DATA:         w_readdata[WIDTH-1:0] = w_data_in;
      ADDR_IRQ_MASK:     w_readdata[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAPTURE: w_readdata[WIDTH-1:0] = r_edge_capture;
      default:           w_readdata = '0;
    endcase
  end

  assign bus.readdata = w_readdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_system_bd_sys_gpio_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_bd_sys_gpio_in
//  Description : Scoreboard bench. Two instances share bus and input stimulus:
//                dut_r (WIDTH 32, rising edges, mask reset 0) and dut_a
//                (WIDTH 16, any edge, mask reset 0x100). Expected values for
//                both are queued by the stimulus and popped by the monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_system_bd_sys_gpio_in;

  typedef struct {
    string       name;
    logic [31:0] er;
    logic [31:0] ea;
  } exp_t;

  logic        clk = 1'b1;
  logic        reset_n;
  logic [31:0] din;
  logic        irq_r, irq_a;
  logic        chk_rd, chk_irq;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t e_rd, e_irq;
  int   n_cmp  = 0;
  int   n_fail = 0;

  system_bd_sys_gpio_in_if bus_r ();
  system_bd_sys_gpio_in_if bus_a ();

  assign bus_a.address    = bus_r.address;
  assign bus_a.chipselect = bus_r.chipselect;
  assign bus_a.write_n    = bus_r.write_n;
  assign bus_a.writedata  = bus_r.writedata;

  system_bd_sys_gpio_in #(
    .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(32'h0)
  ) dut_r (
    .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(din), .irq(irq_r)
  );

  system_bd_sys_gpio_in #(
    .WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_VALUE(32'h100)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(din[15:0]), .irq(irq_a)
  );

  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_rd) begin
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: no expected value queued");
      end else begin
        e_rd = rd_q.pop_front();
        n_cmp += 2;
        if (bus_r.readdata !== e_rd.er) begin
          n_fail++;
          $display("FAIL %s dut_r: readdata=%h expected %h", e_rd.name, bus_r.readdata, e_rd.er);
        end
        if (bus_a.readdata !== e_rd.ea) begin
          n_fail++;
          $display("FAIL %s dut_a: readdata=%h expected %h", e_rd.name, bus_a.readdata, e_rd.ea);
        end
      end
    end
    if (chk_irq) begin
      if (irq_q.size() == 0) begin
        n_fail++;
        $display("FAIL irq_underflow: no expected value queued");
      end else begin
        e_irq = irq_q.pop_front();
        n_cmp += 2;
        if (irq_r !== e_irq.er[0]) begin
          n_fail++;
          $display("FAIL %s dut_r: irq=%b expected %b", e_irq.name, irq_r, e_irq.er[0]);
        end
        if (irq_a !== e_irq.ea[0]) begin
          n_fail++;
          $display("FAIL %s dut_a: irq=%b expected %b", e_irq.name, irq_a, e_irq.ea[0]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    chk_rd           = 1'b0;
    chk_irq          = 1'b0;
    bus_r.chipselect = 1'b0;
    bus_r.write_n    = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arm_rd(input logic [1:0] a, input logic [31:0] er,
                        input logic [31:0] ea, input string name);
    exp_t x;
    x.name = name; x.er = er; x.ea = ea;
    rd_q.push_back(x);
    bus_r.address    = a;
    bus_r.chipselect = 1'b1;
    bus_r.write_n    = 1'b1;
    chk_rd           = 1'b1;
  endtask

  task automatic arm_irq(input logic er, input logic ea, input string name);
    exp_t x;
    x.name = name; x.er = {31'd0, er}; x.ea = {31'd0, ea};
    irq_q.push_back(x);
    chk_irq = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_r.address    = a;
    bus_r.writedata  = d;
    bus_r.chipselect = 1'b1;
    bus_r.write_n    = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n          = 1'b0;
    din              = 32'hA5A5_0001;
    chk_rd           = 1'b0;
    chk_irq          = 1'b0;
    bus_r.address    = 2'd0;
    bus_r.chipselect = 1'b0;
    bus_r.write_n    = 1'b1;
    bus_r.writedata  = 32'h0;
    #2;

    // Reset state
    arm_rd(2'd0, 32'h0, 32'h0, "rst_data"); arm_irq(1'b0, 1'b0, "rst_irq"); tick();
    arm_rd(2'd1, 32'h0, 32'h100, "rst_mask"); tick();
    arm_rd(2'd2, 32'h0, 32'h0, "rst_cap"); tick();

    // Input held high across reset release: no capture during warm-up
    reset_n = 1'b1;
    ticks(3);
    arm_rd(2'd0, 32'hA5A5_0001, 32'h0000_0001, "warm_data"); tick();
    arm_rd(2'd2, 32'h0, 32'h0, "warm_cap"); arm_irq(1'b0, 1'b0, "warm_irq"); tick();

    // Falling edge on bit 0: only the any-edge instance captures it
    wr(2'd1, 32'h1);
    din = 32'hA5A5_0000;
    ticks(3);
    arm_rd(2'd2, 32'h0, 32'h1, "fall_cap"); arm_irq(1'b0, 1'b0, "fall_irq_pre"); tick();
    arm_irq(1'b0, 1'b1, "fall_irq"); wr(2'd2, 32'h1);
    arm_rd(2'd2, 32'h0, 32'h0, "fall_clr"); arm_irq(1'b0, 1'b1, "fall_irq_lag"); tick();
    arm_irq(1'b0, 1'b0, "fall_irq_off"); tick();

    // Rising edge on bit 0: capture after 3 edges, irq one cycle later
    din = 32'hA5A5_0001;
    ticks(3);
    arm_rd(2'd2, 32'h1, 32'h1, "rise_cap"); arm_irq(1'b0, 1'b0, "rise_irq_pre"); tick();
    arm_irq(1'b1, 1'b1, "rise_irq"); wr(2'd2, 32'h1);
    arm_rd(2'd2, 32'h0, 32'h0, "rise_clr"); arm_irq(1'b1, 1'b1, "rise_irq_lag"); tick();
    arm_irq(1'b0, 1'b0, "rise_irq_off"); tick();

    // Four-cycle pulse on bit 5 with mask 0, then unmask
    wr(2'd1, 32'h0);
    din = 32'hA5A5_0021;
    ticks(4);
    din = 32'hA5A5_0001;
    ticks(6);
    arm_rd(2'd2, 32'h20, 32'h20, "pulse_cap"); arm_irq(1'b0, 1'b0, "pulse_irq_masked"); tick();
    wr(2'd1, 32'h20);
    arm_rd(2'd1, 32'h20, 32'h20, "mask_rd"); arm_irq(1'b0, 1'b0, "mask_irq_pre"); tick();
    arm_irq(1'b1, 1'b1, "mask_irq"); tick();

    // Edge on bit 3 detected in the same cycle as its W1C clear
    din = 32'hA5A5_0009;
    ticks(2);
    wr(2'd2, 32'h8);
    arm_rd(2'd2, 32'h28, 32'h28, "set_wins"); tick();
    wr(2'd2, 32'h8);
    arm_rd(2'd2, 32'h20, 32'h20, "w1c_b3"); tick();

    // Zero write to capture, write to DATA, reserved address
    din = 32'hA5A5_0019;
    ticks(3);
    arm_rd(2'd2, 32'h30, 32'h30, "cap30"); tick();
    wr(2'd2, 32'h0);
    arm_rd(2'd2, 32'h30, 32'h30, "w0_nochg"); tick();
    wr(2'd0, 32'hFFFF_FFFF);
    arm_rd(2'd0, 32'hA5A5_0019, 32'h0000_0019, "data_ro"); tick();
    arm_rd(2'd3, 32'h0, 32'h0, "rsvd"); tick();

    // Build capture = 0xF with irq high, then reset asynchronously
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd1, 32'hF);
    din = 32'hA5A5_0010;
    ticks(4);
    din = 32'hA5A5_001F;
    ticks(4);
    arm_rd(2'd2, 32'hF, 32'hF, "pre_rst_cap"); arm_irq(1'b1, 1'b1, "pre_rst_irq"); tick();
    #1;
    reset_n = 1'b0;
    arm_rd(2'd2, 32'h0, 32'h0, "async_cap"); arm_irq(1'b0, 1'b0, "async_irq"); tick();
    arm_rd(2'd1, 32'h0, 32'h100, "async_mask"); tick();
    arm_rd(2'd0, 32'h0, 32'h0, "async_data"); tick();

    // Warm-up restarts after the mid-operation reset
    reset_n = 1'b1;
    ticks(5);
    arm_rd(2'd2, 32'h0, 32'h0, "rewarm_cap"); arm_irq(1'b0, 1'b0, "rewarm_irq"); tick();
    arm_rd(2'd0, 32'hA5A5_001F, 32'h0000_001F, "rewarm_data"); tick();

    // Every queued expectation must have been consumed
    for (int i = 0; i < 10 && (rd_q.size() != 0 || irq_q.size() != 0); i++) tick();
    n_cmp++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d read / %0d irq expectations left, expected 0",
               rd_q.size(), irq_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
